// File: rtl/biotensor_dot_engine_if.sv
// Operand/result handshake bundle for biotensor_dot_engine.
// Both channels use valid/ready: a transfer happens on a rising clk edge where valid and ready are both 1; a producer holds its payload stable while valid=1 and ready=0.
interface biotensor_dot_engine_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_byte;
  logic       out_last;

  modport master (
    output in_valid, in_a, in_b, in_last, out_ready,
    input  in_ready, out_valid, out_byte, out_last
  );

  modport slave (
    input  in_valid, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, out_byte, out_last
  );
endinterface

// File: rtl/biotensor_dot_engine.sv
// Signed 8x8 dot-product accumulator that streams its ACC_W-bit result LSB-first as bytes.
// Optional macro BIOTENSOR_SATURATE_EN switches the accumulator from wrap-around to saturating adds.
module biotensor_dot_engine #(
  parameter int ACC_W   = 20,
  parameter int MAX_LEN = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  biotensor_dot_engine_if.slave   bus,
  output logic                    busy,
  output logic                    len_err,
  output logic [1:0]              dbg_state
);

  localparam int NB    = (ACC_W + 7) / 8;
  localparam int EXT_W = 8 * NB;
  localparam int CW    = $clog2(MAX_LEN + 1);
  localparam int IW    = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [CW-1:0]            count_q, count_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic                     in_ready_q, in_ready_d;
  logic                     out_valid_q, out_valid_d;
  logic [7:0]               out_byte_q, out_byte_d;
  logic                     out_last_q, out_last_d;
  logic                     busy_q, busy_d;
  logic                     len_err_q, len_err_d;

  logic                     accept;
  logic                     byte_taken;
  logic                     overrun;
  logic                     vec_end;
  logic signed [15:0]       prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc_sum;
  logic [CW-1:0]            new_count;
  logic [EXT_W-1:0]         acc_ext;

  function automatic logic signed [ACC_W-1:0] add_acc(
    input logic signed [ACC_W-1:0] x,
    input logic signed [ACC_W-1:0] y
  );
`ifdef BIOTENSOR_SATURATE_EN
    logic [ACC_W:0] s;
    s = {x[ACC_W-1], x} + {y[ACC_W-1], y};
    // The two top bits disagree exactly when the signed sum left the ACC_W range.
    if (s[ACC_W] != s[ACC_W-1]) begin
      return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
    return s[ACC_W-1:0];
`else
    return x + y;
`endif
  endfunction

  always_comb begin
    accept     = bus.in_valid && in_ready_q;
    byte_taken = out_valid_q && bus.out_ready;
    prod       = $signed(bus.in_a) * $signed(bus.in_b);
    prod_ext   = ACC_W'(prod);
    acc_sum    = add_acc(acc_q, prod_ext);
    new_count  = (state_q == IDLE) ? CW'(1) : count_q + CW'(1);
    // The pair that brings the count to MAX_LEN closes the vector even without in_last.
    overrun    = accept && !bus.in_last && (new_count == CW'(MAX_LEN));
    vec_end    = bus.in_last || overrun;

    state_d   = state_q;
    acc_d     = acc_q;
    count_d   = count_q;
    idx_d     = idx_q;
    len_err_d = len_err_q | overrun;

    case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d   = prod_ext;
          count_d = new_count;
          state_d = vec_end ? DRAIN : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          acc_d   = acc_sum;
          count_d = new_count;
          state_d = vec_end ? DRAIN : ACCUM;
        end
      end
      DRAIN: begin
        if (byte_taken) begin
          if (idx_q == IW'(NB - 1)) begin
            state_d = IDLE;
            idx_d   = '0;
            count_d = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
        count_d = '0;
      end
    endcase

    // Outputs are registered from next-state values so they change only on clk.
    acc_ext     = EXT_W'(acc_d);
    in_ready_d  = (state_d != DRAIN);
    out_valid_d = (state_d == DRAIN);
    out_byte_d  = out_valid_d ? 8'(acc_ext >> {idx_d, 3'b000}) : 8'h00;
    out_last_d  = out_valid_d && (idx_d == IW'(NB - 1));
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      count_q     <= '0;
      idx_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_byte_q  <= 8'h00;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_byte_q  <= out_byte_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      len_err_q   <= len_err_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_byte  = out_byte_q;
  assign bus.out_last  = out_last_q;
  assign busy          = busy_q;
  assign len_err       = len_err_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_biotensor_dot_engine.sv
// Directed bench for biotensor_dot_engine: a vector table plus hand-written corner sequences.
module tb_biotensor_dot_engine;

  localparam int NB = 3;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic       clk;
  logic       rst;
  logic       busy;
  logic       len_err;
  logic [1:0] dbg_state;

  biotensor_dot_engine_if bus ();

  biotensor_dot_engine #(.ACC_W(20), .MAX_LEN(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .busy      (busy),
    .len_err   (len_err),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_chk  = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_result(input logic [23:0] r);
    for (int i = 0; i < NB; i++) exp_q.push_back(r[8*i +: 8]);
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_byte",  32'(bus.out_byte),  32'd0);
    chk("rst_out_last",  32'(bus.out_last),  32'd0);
    chk("rst_busy",      32'(busy),          32'd0);
    chk("rst_len_err",   32'(len_err),       32'd0);
    chk("rst_state",     32'(dbg_state),     32'(S_IDLE));
  endtask

  // Presents one pair and returns #1 after the edge that accepted it.
  task automatic send_pair(input int a, input int b, input logic last);
    int cyc;
    bus.in_valid = 1'b1;
    bus.in_a     = 8'(a);
    bus.in_b     = 8'(b);
    bus.in_last  = last;
    cyc = 0;
    while (bus.in_ready !== 1'b1 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (cyc >= 50) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 50 cycles");
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Takes one byte with out_ready=1 and compares it against the head of exp_q.
  task automatic recv_byte(input string name, input logic exp_last);
    int cyc;
    logic [7:0] e;
    bus.out_ready = 1'b1;
    cyc = 0;
    while (bus.out_valid !== 1'b1 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    chk({name, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({name, "_byte"},  32'(bus.out_byte),  32'(e));
    chk({name, "_last"},  32'(bus.out_last),  32'(exp_last));
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic drain_all(input string name);
    for (int i = 0; i < NB; i++) recv_byte(name, (i == NB - 1));
    chk({name, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [2:0]      n;
    logic [3:0][7:0] a;
    logic [3:0][7:0] b;
    logic [23:0]     res;
  } vec_t;

  vec_t vecs[5];

  function automatic vec_t mk(input int n, input int a0, input int b0, input int a1,
                              input int b1, input int a2, input int b2, input logic [23:0] r);
    vec_t v;
    v.n    = 3'(n);
    v.a    = '0;
    v.b    = '0;
    v.a[0] = 8'(a0); v.b[0] = 8'(b0);
    v.a[1] = 8'(a1); v.b[1] = 8'(b1);
    v.a[2] = 8'(a2); v.b[2] = 8'(b2);
    v.res  = r;
    return v;
  endfunction

  // ---------------- test ----------------
  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = 8'h00;
    bus.in_b      = 8'h00;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    // 12-10-7 = -5 ; 25 ; 2*16129 ; -16256-1+10000 = -6257 ; 0+1+0
    vecs[0] = mk(3,    3,   4,  -2,  5,   7,  -1, 24'hFFFFFB);
    vecs[1] = mk(1,    5,   5,   0,  0,   0,   0, 24'h000019);
    vecs[2] = mk(2,  127, 127, 127, 127,  0,   0, 24'h007E02);
    vecs[3] = mk(3, -128, 127,   1,  -1, 100, 100, 24'hFFE78F);
    vecs[4] = mk(3,    0,   0,  -1,  -1,   0,   9, 24'h000001);

    repeat (2) @(posedge clk);
    #1;
    do_reset();
    @(posedge clk); #1;
    chk("idle_in_ready", 32'(bus.in_ready), 32'd1);

    for (int v = 0; v < 5; v++) begin
      for (int p = 0; p < int'(vecs[v].n); p++) begin
        send_pair(int'($signed(vecs[v].a[p])), int'($signed(vecs[v].b[p])),
                  (p == int'(vecs[v].n) - 1));
        if (p < int'(vecs[v].n) - 1) chk("tbl_accum_state", 32'(dbg_state), 32'(S_ACCUM));
      end
      chk("tbl_latency_valid", 32'(bus.out_valid), 32'd1);
      chk("tbl_drain_ready",   32'(bus.in_ready),  32'd0);
      push_result(vecs[v].res);
      drain_all("tbl");
    end

    // Backpressure: first byte must hold while out_ready=0.
    send_pair(3, 4, 1'b0);
    send_pair(-2, 5, 1'b0);
    send_pair(7, -1, 1'b1);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk("bp_byte",     32'(bus.out_byte),  32'hFB);
      chk("bp_valid",    32'(bus.out_valid), 32'd1);
      chk("bp_in_ready", 32'(bus.in_ready),  32'd0);
    end
    push_result(24'hFFFFFB);
    drain_all("bp");

    // Max-magnitude: 16 * 16384 = 0x40000 fits in 20 bits.
    for (int p = 0; p < 16; p++) send_pair(-128, -128, (p == 15));
    chk("max_len_err", 32'(len_err), 32'd0);
    push_result(24'h040000);
    drain_all("max");

    // in_valid gaps are ignored, even with garbage on the data lines.
    send_pair(2, 3, 1'b0);
    bus.in_a    = 8'd100;
    bus.in_b    = 8'd100;
    bus.in_last = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      chk("gap_state", 32'(dbg_state), 32'(S_ACCUM));
    end
    bus.in_last = 1'b0;
    send_pair(1, 1, 1'b1);
    push_result(24'h000007);
    drain_all("gap");

    // Length overrun: 16th pair closes the vector, 17th is held off.
    for (int p = 0; p < 16; p++) begin
      send_pair(1, 1, 1'b0);
      if (p == 14) chk("ovr_len_err_early", 32'(len_err), 32'd0);
    end
    chk("ovr_len_err",  32'(len_err),   32'd1);
    chk("ovr_state",    32'(dbg_state), 32'(S_DRAIN));
    bus.in_valid = 1'b1;
    bus.in_a     = 8'd1;
    bus.in_b     = 8'd1;
    push_result(24'h000010);
    for (int i = 0; i < NB; i++) begin
      chk("ovr_in_ready", 32'(bus.in_ready), 32'd0);
      recv_byte("ovr", (i == NB - 1));
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("ovr_idle",   32'(dbg_state), 32'(S_IDLE));
    chk("ovr_sticky", 32'(len_err),   32'd1);

    // Reset during ACCUM discards the partial sum and clears len_err.
    send_pair(10, 10, 1'b0);
    send_pair(3, 3, 1'b0);
    do_reset();
    send_pair(5, 5, 1'b1);
    push_result(24'h000019);
    drain_all("rst_acc");

    // Reset during DRAIN after byte 0 drops the undrained bytes.
    send_pair(1, 2, 1'b1);
    exp_q.push_back(8'h02);
    recv_byte("rst_drn", 1'b0);
    do_reset();
    send_pair(5, 5, 1'b1);
    push_result(24'h000019);
    drain_all("rst_drn2");

    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
